uart_receive_frame: RTL and testbench

- Receive-side counterpart of the UART transmit enable logic.
- Samples the asynchronous serial line on a 16x oversample tick and detects and validates the start bit.
- Assembles DATA_BITS LSB-first and checks the stop bit.
- Presents the character to the consumer through a ready/read handshake, with framing-error and overrun flags.

---
 rtl/uart_receive_frame_if.sv | 21 ++
 rtl/uart_receive_frame.sv | 148 ++++++++++++++
 tb/tb_uart_receive_frame.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_receive_frame_if.sv
// Consumer-side handshake bundle of the UART receiver: character, status flags and read strobe.
interface uart_receive_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 charRead;
    logic [DATA_BITS-1:0] dataOut;
    logic                 charReady;
    logic                 frameError;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  charRead,
        output dataOut, charReady, frameError, overrun, busy
    );

    modport slave (
        output charRead,
        input  dataOut, charReady, frameError, overrun, busy
    );
endinterface

// File: rtl/uart_receive_frame.sv
// UART receiver: oversampled start-bit validation, LSB-first assembly, stop-bit check,
// and a ready/read handshake with framing-error and overrun reporting.
module uart_receive_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxIn,
    input  logic                  sampleTick,
    uart_receive_frame_if.master  rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (rx_if.charRead) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end
            S_START: begin
                if (sampleTick) begin
                    if (tick_cnt_q == HALF_M1) begin
                        if (!rx_s_q) begin
                            state_d     = S_DATA;
                            tick_cnt_d  = '0;
                            bit_idx_d   = '0;
                            frame_err_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (sampleTick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        // Shifting in at the MSB leaves bit 0 holding the first received bit.
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_d  = bit_idx_q + BW'(1);
                        tick_cnt_d = '0;
                        if (bit_idx_q == LAST_BIT) state_d = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (sampleTick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                            // A read on this same edge frees the slot for the new character.
                            if (!ready_q || rx_if.charRead) begin
                                data_d    = shift_q;
                                ready_d   = 1'b1;
                                overrun_d = 1'b0;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rxIn;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.dataOut    = data_q;
    assign rx_if.charReady  = ready_q;
    assign rx_if.frameError = frame_err_q;
    assign rx_if.overrun    = overrun_q;
    assign rx_if.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_receive_frame.sv
// Directed bench for uart_receive_frame: 16 clk per bit with sampleTick tied high.
module tb_uart_receive_frame;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic rxIn       = 1'b1;
    logic sampleTick = 1'b1;
    int   checks     = 0;
    int   errors     = 0;

    uart_receive_frame_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_receive_frame #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxIn       (rxIn),
        .sampleTick (sampleTick),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge count starts at the drive of the start bit; E is edge 3, the stop sample edge 155.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int rd_edge, output int rise_edge);
        logic [9:0] bits;
        int         edge_n;
        logic       prev;
        bits      = {stop_bit, data, 1'b0};
        edge_n    = 0;
        rise_edge = -1;
        prev      = rx_if.charReady;
        for (int b = 0; b < 10; b++) begin
            rxIn = bits[b];
            for (int c = 0; c < 16; c++) begin
                rx_if.charRead = (edge_n + 1 == rd_edge);
                tick();
                edge_n++;
                if (rise_edge < 0 && !prev && rx_if.charReady) rise_edge = edge_n;
                prev = rx_if.charReady;
            end
        end
        rx_if.charRead = 1'b0;
    endtask

    task automatic read_char();
        rx_if.charRead = 1'b1;
        tick();
        rx_if.charRead = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_if.charRead = 1'b0;
        repeat (3) tick();
        checks++; if (rx_if.dataOut !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_if.dataOut); end
        checks++; if ({rx_if.charReady, rx_if.frameError, rx_if.overrun, rx_if.busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rx_if.charReady, rx_if.frameError, rx_if.overrun, rx_if.busy}); end
        reset = 1'b1;
        repeat (4) tick();
        checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", rx_if.busy); end
    endtask

    task automatic test_basic();
        int rise;
        send_frame(8'h55, 1'b1, 0, rise);
        checks++; if (rise !== 155) begin errors++; $display("FAIL basic_latency got %0d exp 155 (152 after E)", rise); end
        checks++; if (rx_if.dataOut !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", rx_if.dataOut); end
        checks++; if ({rx_if.charReady, rx_if.frameError, rx_if.overrun} !== 3'b100) begin errors++; $display("FAIL basic_flags got %b exp 100", {rx_if.charReady, rx_if.frameError, rx_if.overrun}); end
        checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", rx_if.busy); end
        read_char();
        checks++; if (rx_if.charReady !== 1'b0) begin errors++; $display("FAIL basic_read got %b exp 0", rx_if.charReady); end
        read_char();
        checks++; if ({rx_if.charReady, rx_if.dataOut} !== {1'b0, 8'h55}) begin errors++; $display("FAIL basic_idle_read got %b/%h exp 0/55", rx_if.charReady, rx_if.dataOut); end
    endtask

    task automatic test_glitch();
        int   drop;
        logic seen_busy;
        drop      = -1;
        seen_busy = 1'b0;
        rxIn      = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 5) rxIn = 1'b1;
            if (i == 6 && rx_if.busy) seen_busy = 1'b1;
            if (drop < 0 && seen_busy && !rx_if.busy) drop = i;
        end
        checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b exp 1", seen_busy); end
        checks++; if (drop !== 11) begin errors++; $display("FAIL glitch_busy_drop got %0d exp 11", drop); end
        checks++; if ({rx_if.charReady, rx_if.frameError, rx_if.dataOut} !== {2'b00, 8'h55}) begin errors++; $display("FAIL glitch_state got %b%b/%h exp 00/55", rx_if.charReady, rx_if.frameError, rx_if.dataOut); end
    endtask

    task automatic test_break();
        int rise;
        int busy_low;
        int drop;
        send_frame(8'hA3, 1'b0, 0, rise);
        checks++; if (rx_if.frameError !== 1'b1) begin errors++; $display("FAIL break_ferr got %b exp 1", rx_if.frameError); end
        checks++; if ({rx_if.charReady, rx_if.dataOut} !== {1'b0, 8'h55}) begin errors++; $display("FAIL break_keep got %b/%h exp 0/55", rx_if.charReady, rx_if.dataOut); end
        busy_low = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!rx_if.busy || rx_if.charReady) busy_low++;
        end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL break_hold got %0d bad cycles exp 0", busy_low); end
        rxIn = 1'b1;
        drop = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (drop < 0 && !rx_if.busy) drop = i;
        end
        checks++; if (drop !== 3) begin errors++; $display("FAIL break_release got %0d exp 3", drop); end
        send_frame(8'h3C, 1'b1, 0, rise);
        checks++; if ({rx_if.charReady, rx_if.frameError, rx_if.dataOut} !== {2'b10, 8'h3C}) begin errors++; $display("FAIL break_recover got %b%b/%h exp 10/3c", rx_if.charReady, rx_if.frameError, rx_if.dataOut); end
        read_char();
    endtask

    task automatic test_back_to_back();
        int rise;
        send_frame(8'h11, 1'b1, 0, rise);
        checks++; if ({rx_if.charReady, rx_if.overrun, rx_if.dataOut} !== {2'b10, 8'h11}) begin errors++; $display("FAIL b2b_first got %b%b/%h exp 10/11", rx_if.charReady, rx_if.overrun, rx_if.dataOut); end
        send_frame(8'h22, 1'b1, 0, rise);
        checks++; if ({rx_if.charReady, rx_if.overrun, rx_if.dataOut} !== {2'b11, 8'h11}) begin errors++; $display("FAIL b2b_overrun got %b%b/%h exp 11/11", rx_if.charReady, rx_if.overrun, rx_if.dataOut); end
        read_char();
        checks++; if ({rx_if.charReady, rx_if.overrun} !== 2'b00) begin errors++; $display("FAIL b2b_read got %b exp 00", {rx_if.charReady, rx_if.overrun}); end
    endtask

    task automatic test_read_same_edge();
        int rise;
        send_frame(8'h11, 1'b1, 0, rise);
        send_frame(8'h44, 1'b1, 0, rise);
        checks++; if ({rx_if.overrun, rx_if.dataOut} !== {1'b1, 8'h11}) begin errors++; $display("FAIL same_setup got %b/%h exp 1/11", rx_if.overrun, rx_if.dataOut); end
        send_frame(8'h22, 1'b1, 155, rise);
        checks++; if ({rx_if.charReady, rx_if.overrun, rx_if.dataOut} !== {2'b10, 8'h22}) begin errors++; $display("FAIL same_edge got %b%b/%h exp 10/22", rx_if.charReady, rx_if.overrun, rx_if.dataOut); end
        read_char();
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int         rise;
        v    = 8'hC9;
        rxIn = 1'b0;
        repeat (16) tick();
        for (int b = 0; b < 4; b++) begin
            rxIn = v[b];
            repeat (16) tick();
        end
        rxIn = v[4];
        repeat (4) tick();
        checks++; if (rx_if.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", rx_if.busy); end
        reset = 1'b0;
        rxIn  = 1'b1;
        #1;
        checks++; if ({rx_if.charReady, rx_if.frameError, rx_if.overrun, rx_if.busy, rx_if.dataOut} !== 12'h000) begin errors++; $display("FAIL mid_reset got %b%b%b%b/%h exp 0000/00", rx_if.charReady, rx_if.frameError, rx_if.overrun, rx_if.busy, rx_if.dataOut); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) tick();
        checks++; if ({rx_if.charReady, rx_if.busy, rx_if.dataOut} !== 10'h000) begin errors++; $display("FAIL mid_release got %b%b/%h exp 00/00", rx_if.charReady, rx_if.busy, rx_if.dataOut); end
        send_frame(8'h7E, 1'b1, 0, rise);
        checks++; if (rise !== 155) begin errors++; $display("FAIL mid_latency got %0d exp 155", rise); end
        checks++; if ({rx_if.charReady, rx_if.frameError, rx_if.overrun, rx_if.dataOut} !== {3'b100, 8'h7E}) begin errors++; $display("FAIL mid_next got %b%b%b/%h exp 100/7e", rx_if.charReady, rx_if.frameError, rx_if.overrun, rx_if.dataOut); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_read_same_edge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
